chash_poly_reader: RTL and testbench

// - Reads back the sparse challenge polynomial c held in memory region {2'b11,word[7:0]} and
//   re-emits its nonzero coefficients as a stream of Chash_addr-format indices.
// - Each word packs two coefficients, for two moduli in parallel:
//     Din_24 = {q1 coef 2w [47:24], q1 coef 2w+1 [23:0]}
//     Din_25 = {q2 coef 2w [49:25], q2 coef 2w+1 [24:0]}
// - Encodings: +1 = {24'h001041, 25'h1DE0409}; -1 = {24'hFBEFC0, 25'h01DFBF8}; 0 = both zero.
// - Feeds the challenge-multiply stage and self-checks the challenge written upstream.

---
 rtl/chash_poly_reader.sv | 257 +++++++++++++++++++++++++
 tb/tb_chash_poly_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chash_poly_reader.sv
// chash_poly_reader: scans the challenge polynomial region {2'b11, word[7:0]} and streams
// the nonzero coefficients as Chash_addr indices {6'b0, index[8:0], sign} through a small
// first-word-fall-through FIFO.
// Build macro CHASH_CHECK_EN: strict 0/+1/-1 decode across both moduli plus a weight == TAU
// check at completion. Without it, only the q1 half is decoded and err stays low.
module chash_poly_reader #(
  parameter int RD_LAT  = 1,
  parameter int FIFO_DW = 8,
  parameter int TAU     = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_rd_en,
  output logic [9:0]  o_rd_addr,
  input  logic [47:0] i_Din_24,
  input  logic [49:0] i_Din_25,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_out_idx,
  output logic [9:0]  o_weight,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int PW = $clog2(FIFO_DW);
  localparam int CW = PW + 1;
  localparam logic [23:0] P1_24 = 24'h001041;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_word;
  logic              r_rd_en;
  logic [9:0]        r_rd_addr;
  logic [RD_LAT-1:0] r_dly_vld;
  logic [7:0]        r_dly_word [RD_LAT];
  logic [9:0]        r_fifo_mem [FIFO_DW];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [9:0]        r_weight;
  logic              r_err;

  logic              w_issue;
  logic              w_clear;
  logic [2:0]        w_inflight;
  logic [15:0]       w_credit_use;
  logic              w_credit_ok;
  logic              w_dvalid;
  logic [7:0]        w_dword;
  logic [23:0]       w_hi24;
  logic [23:0]       w_lo24;
  logic              w_hi_push;
  logic              w_hi_sign;
  logic              w_lo_push;
  logic              w_lo_sign;
  logic              w_err_set;
  logic [1:0]        w_npush;
  logic              w_pop;
  logic [9:0]        w_hi_ent;
  logic [9:0]        w_lo_ent;
  logic [9:0]        w_first_ent;
  logic              w_wr_first;
  logic              w_wr_second;
  logic [PW-1:0]     w_wr_ptr_p1;
  logic [10:0]       w_wsum;

  // The oldest delay-line stage lines up with the data the memory is returning now
  assign w_dvalid = r_dly_vld[RD_LAT-1];
  assign w_dword  = r_dly_word[RD_LAT-1];
  assign w_hi24   = i_Din_24[47:24];
  assign w_lo24   = i_Din_24[23:0];

`ifdef CHASH_CHECK_EN
  localparam logic [24:0] P1_25 = 25'h1DE0409;
  localparam logic [23:0] M1_24 = 24'hFBEFC0;
  localparam logic [24:0] M1_25 = 25'h01DFBF8;

  logic        w_bad;
  logic [24:0] w_hi25;
  logic [24:0] w_lo25;
  logic        w_hi_plus;
  logic        w_hi_minus;
  logic        w_hi_zero;
  logic        w_lo_plus;
  logic        w_lo_minus;
  logic        w_lo_zero;

  assign w_hi25     = i_Din_25[49:25];
  assign w_lo25     = i_Din_25[24:0];
  assign w_hi_plus  = (w_hi24 == P1_24) && (w_hi25 == P1_25);
  assign w_hi_minus = (w_hi24 == M1_24) && (w_hi25 == M1_25);
  assign w_hi_zero  = (w_hi24 == 24'h0) && (w_hi25 == 25'h0);
  assign w_lo_plus  = (w_lo24 == P1_24) && (w_lo25 == P1_25);
  assign w_lo_minus = (w_lo24 == M1_24) && (w_lo25 == M1_25);
  assign w_lo_zero  = (w_lo24 == 24'h0) && (w_lo25 == 25'h0);

  // Only exact +1/-1 slots are pushed; anything other than 0/+1/-1 is flagged and dropped
  always_comb begin
    w_hi_push = w_dvalid & (w_hi_plus | w_hi_minus);
    w_hi_sign = w_hi_minus;
    w_lo_push = w_dvalid & (w_lo_plus | w_lo_minus);
    w_lo_sign = w_lo_minus;
    w_bad     = w_dvalid & (~(w_hi_plus | w_hi_minus | w_hi_zero) |
                            ~(w_lo_plus | w_lo_minus | w_lo_zero));
    w_err_set = w_bad |
                ((r_state == S_DRAIN) && (w_state_nxt == S_DONE) && (r_weight != 10'(TAU)));
  end
`else
  logic w_unused_din25;

  assign w_unused_din25 = ^i_Din_25;

  // Lenient decode: the q1 half alone decides presence and sign
  always_comb begin
    w_hi_push = w_dvalid & (w_hi24 != 24'h0);
    w_hi_sign = (w_hi24 != P1_24);
    w_lo_push = w_dvalid & (w_lo24 != 24'h0);
    w_lo_sign = (w_lo24 != P1_24);
    w_err_set = 1'b0;
  end
`endif

  assign w_hi_ent    = {w_dword, 1'b0, w_hi_sign};
  assign w_lo_ent    = {w_dword, 1'b1, w_lo_sign};
  assign w_npush     = {1'b0, w_hi_push} + {1'b0, w_lo_push};
  assign w_wr_first  = w_hi_push | w_lo_push;
  assign w_wr_second = w_hi_push & w_lo_push;
  assign w_first_ent = w_hi_push ? w_hi_ent : w_lo_ent;
  assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);
  assign w_pop       = (r_count != CW'(0)) & i_out_ready;
  assign w_wsum      = 11'(r_weight) + 11'(w_npush);

  // Every outstanding read may still land two entries, so reserve room for all of them
  always_comb begin
    w_inflight = {2'b00, r_rd_en};
    for (int k = 0; k < RD_LAT; k++) begin
      w_inflight = w_inflight + {2'b00, r_dly_vld[k]};
    end
    w_credit_use = 16'(r_count) + {12'h000, w_inflight, 1'b0} + 16'd2;
    w_credit_ok  = (w_credit_use <= 16'(FIFO_DW));
  end

  // Next-state logic: scan issues reads under credit, drain waits for the pipe and FIFO to empty
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_clear     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SCAN;
          w_clear     = 1'b1;
        end
      end
      S_SCAN: begin
        o_busy = 1'b1;
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_word == 8'd255) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if ((w_inflight == 3'd0) && (r_count == CW'(0))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, read strobe, read-tag delay line, weight and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_word    <= 8'd0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= 10'd0;
      r_dly_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_dly_word[k] <= 8'd0;
      end
      r_weight  <= 10'd0;
      r_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_en       <= w_issue;
      r_dly_vld[0]  <= r_rd_en;
      r_dly_word[0] <= r_rd_addr[7:0];
      for (int k = 1; k < RD_LAT; k++) begin
        r_dly_vld[k]  <= r_dly_vld[k-1];
        r_dly_word[k] <= r_dly_word[k-1];
      end
      if (w_issue) begin
        r_rd_addr <= {2'b11, r_word};
        r_word    <= r_word + 8'd1;
      end
      if (w_clear) begin
        r_word   <= 8'd0;
        r_weight <= 10'd0;
        r_err    <= 1'b0;
      end else begin
        if (w_npush != 2'd0) begin
          r_weight <= (w_wsum > 11'd512) ? 10'd512 : w_wsum[9:0];
        end
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; a 2-wide push and a pop may share a cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_npush);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + CW'(w_npush) - CW'(w_pop);
    end
  end

  // FIFO storage; upper-slot entry goes first so indices leave in ascending order
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_wr_first) begin
        r_fifo_mem[r_wr_ptr] <= w_first_ent;
      end
      if (w_wr_second) begin
        r_fifo_mem[w_wr_ptr_p1] <= w_lo_ent;
      end
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_out_valid = (r_count != CW'(0));
  assign o_out_idx   = o_out_valid ? {6'b000000, r_fifo_mem[r_rd_ptr]} : 16'h0000;
  assign o_weight    = r_weight;
  assign o_err       = r_err;

endmodule

// File: tb/tb_chash_poly_reader.sv
// tb_chash_poly_reader: scoreboard bench for chash_poly_reader with a latency-1 memory model
// and a consumer whose ready pattern is selectable (always, random, long stalls).
`timescale 1ns/1ps
module tb_chash_poly_reader;

  localparam int RD_LAT  = 1;
  localparam int FIFO_DW = 8;
  localparam int TAU     = 128;
`ifdef CHASH_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif
  localparam logic [23:0] P24 = 24'h001041;
  localparam logic [24:0] P25 = 25'h1DE0409;
  localparam logic [23:0] M24 = 24'hFBEFC0;
  localparam logic [24:0] M25 = 25'h01DFBF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rdEn;
  logic [9:0]  rdAddr;
  logic [47:0] din24;
  logic [49:0] din25;
  logic        outValid;
  logic        outReady;
  logic [15:0] outIdx;
  logic [9:0]  weight;
  logic        busy;
  logic        done;
  logic        err;

  logic [47:0] mem24 [256];
  logic [49:0] mem25 [256];
  logic [15:0] expQ [$];

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          readyMode   = 0;
  int          lowLeft     = 0;
  int          readCnt     = 0;
  int          badAddr     = 0;
  int          doneCnt     = 0;
  bit          firstSeen   = 1'b0;
  bit          lastIssued  = 1'b0;
  bit          sbEnable    = 1'b0;
  bit          holdPrev    = 1'b0;
  logic [9:0]  firstAddr   = 10'd0;
  logic [15:0] holdIdx     = 16'd0;
  logic        memEn;
  logic [9:0]  memAddr;

  chash_poly_reader #(.RD_LAT(RD_LAT), .FIFO_DW(FIFO_DW), .TAU(TAU)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_rd_en     (rdEn),
    .o_rd_addr   (rdAddr),
    .i_Din_24    (din24),
    .i_Din_25    (din25),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_idx   (outIdx),
    .o_weight    (weight),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Memory model: a read strobed in cycle t returns its word during cycle t+1; garbage otherwise
  always @(posedge clk) begin
    memEn   = rdEn;
    memAddr = rdAddr;
    if (memEn) begin
      readCnt++;
      if (memAddr[9:8] != 2'b11) badAddr++;
      if (!firstSeen) begin
        firstSeen = 1'b1;
        firstAddr = memAddr;
      end
      if (memAddr == 10'h3FF) lastIssued = 1'b1;
    end
    #1;
    if (memEn) begin
      din24 = mem24[memAddr[7:0]];
      din25 = mem25[memAddr[7:0]];
    end else begin
      din24 = {16'($urandom), $urandom};
      din25 = {18'($urandom), $urandom};
    end
  end

  // Consumer and scoreboard: pick ready for the coming edge, then check what that edge will take
  always @(negedge clk) begin
    case (readyMode)
      0: outReady = 1'b1;
      1: outReady = 1'($urandom_range(0, 1));
      default: begin
        if (lowLeft > 0) begin
          outReady = 1'b0;
          lowLeft--;
        end else if ($urandom_range(0, 15) == 0) begin
          lowLeft  = $urandom_range(10, 40);
          outReady = 1'b0;
        end else begin
          outReady = 1'b1;
        end
      end
    endcase
    if (done) doneCnt++;
    if (sbEnable) begin
      if (holdPrev) begin
        checkOutput("holdValid", outValid, 1);
        checkOutput("holdIdx", outIdx, holdIdx);
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) checkOutput("extraIdx", outIdx, 32'hFFFF_FFFF);
        else checkOutput("outIdx", outIdx, expQ.pop_front());
      end
      holdPrev = outValid && !outReady;
      holdIdx  = outIdx;
    end else begin
      holdPrev = 1'b0;
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      mem24[i] = 48'h0;
      mem25[i] = 50'h0;
    end
    expQ.delete();
  endtask

  task automatic setSlot(input int idx, input bit neg);
    int w;
    w = idx / 2;
    if (idx % 2 == 0) begin
      mem24[w][47:24] = neg ? M24 : P24;
      mem25[w][49:25] = neg ? M25 : P25;
    end else begin
      mem24[w][23:0] = neg ? M24 : P24;
      mem25[w][24:0] = neg ? M25 : P25;
    end
  endtask

  // 128 distinct random indices with random signs; expectations come straight from the picks
  task automatic buildRandom();
    bit used [512];
    int picked;
    int idx;
    bit sgn;
    clearMem();
    picked = 0;
    while (picked < 128) begin
      idx = $urandom_range(0, 511);
      if (!used[idx]) begin
        used[idx] = 1'b1;
        picked++;
      end
    end
    for (int i = 0; i < 512; i++) begin
      if (used[i]) begin
        sgn = 1'($urandom_range(0, 1));
        setSlot(i, sgn);
        expQ.push_back({6'b000000, 9'(i), sgn});
      end
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".rdEn"}, rdEn, 0);
    checkOutput({name, ".rdAddr"}, rdAddr, 0);
    checkOutput({name, ".outValid"}, outValid, 0);
    checkOutput({name, ".outIdx"}, outIdx, 0);
    checkOutput({name, ".weight"}, weight, 0);
    checkOutput({name, ".busy"}, busy, 0);
    checkOutput({name, ".done"}, done, 0);
    checkOutput({name, ".err"}, err, 0);
  endtask

  // One full scan: pulse start, wait (bounded) for done, then check the scan-level results
  task automatic applyStimulus(input string name, input int rMode, input int expWeight,
                               input bit expErr, input bit pokeDrain);
    bit seenDone;
    bit poked;
    logic errAtDone;
    readyMode  = rMode;
    readCnt    = 0;
    badAddr    = 0;
    doneCnt    = 0;
    firstSeen  = 1'b0;
    lastIssued = 1'b0;
    sbEnable   = 1'b1;
    errAtDone  = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checkOutput({name, ".busyAfterStart"}, busy, 1);
    checkOutput({name, ".weightCleared"}, weight, 0);
    seenDone = 1'b0;
    poked    = 1'b0;
    for (int c = 0; c < 20000 && !seenDone; c++) begin
      @(negedge clk);
      if (pokeDrain && !poked && lastIssued) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seenDone  = 1'b1;
        errAtDone = err;
      end
    end
    start = 1'b0;
    checkOutput({name, ".doneSeen"}, seenDone, 1);
    checkOutput({name, ".errAtDone"}, errAtDone, expErr);
    repeat (5) @(negedge clk);
    checkOutput({name, ".doneCount"}, doneCnt, 1);
    checkOutput({name, ".weight"}, weight, expWeight);
    checkOutput({name, ".errHeld"}, err, expErr);
    checkOutput({name, ".leftover"}, expQ.size(), 0);
    checkOutput({name, ".reads"}, readCnt, 256);
    checkOutput({name, ".badAddr"}, badAddr, 0);
    checkOutput({name, ".firstAddr"}, firstAddr, 10'h300);
    checkOutput({name, ".idleBusy"}, busy, 0);
  endtask

  initial begin
    bit found;
    rst      = 1'b1;
    start    = 1'b0;
    outReady = 1'b1;
    din24    = 48'h0;
    din25    = 50'h0;
    clearMem();
    repeat (3) @(negedge clk);
    checkResetValues("por");
    rst = 1'b0;
    @(negedge clk);

    // +1 at index 0, -1 at index 511
    clearMem();
    setSlot(0, 1'b0);
    setSlot(511, 1'b1);
    expQ.push_back(16'h0000);
    expQ.push_back(16'h03FF);
    applyStimulus("ends", 0, 2, CHECK_ON, 1'b0);

    // word 5 = {+1, -1}, ready always high
    clearMem();
    setSlot(10, 1'b0);
    setSlot(11, 1'b1);
    expQ.push_back(16'h0014);
    expQ.push_back(16'h0017);
    applyStimulus("word5", 0, 2, CHECK_ON, 1'b0);

    // 128 random indices under random and long-stall backpressure
    buildRandom();
    applyStimulus("rand1", 1, 128, 1'b0, 1'b0);
    buildRandom();
    applyStimulus("rand2", 2, 128, 1'b0, 1'b0);

    // word 7 upper = +1 (index 14), lower = q1 1 / q2 0
    clearMem();
    setSlot(14, 1'b0);
    mem24[7][23:0] = 24'h000001;
    mem25[7][24:0] = 25'h0;
    expQ.push_back(16'h001C);
`ifdef CHASH_CHECK_EN
    applyStimulus("oddSlot", 0, 1, 1'b1, 1'b0);
`else
    expQ.push_back(16'h001F);
    applyStimulus("oddSlot", 0, 2, 1'b0, 1'b0);
`endif

    // reset while word 100 is being read, then a clean rescan
    buildRandom();
    sbEnable  = 1'b0;
    readyMode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (rdEn && rdAddr == 10'h364) found = 1'b1;
    end
    checkOutput("midScan.reachWord100", found, 1);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midScan");
    rst = 1'b0;
    buildRandom();
    applyStimulus("afterRst", 1, 128, 1'b0, 1'b0);

    // start pulsed while draining must be ignored
    buildRandom();
    applyStimulus("drainStart", 2, 128, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
